// File: rtl/iob_rom_np_arb_pkg.sv
// Shared definitions for the N-port round-robin ROM front end: port limits,
// pointer sizing and one-hot decoding used by the arbiter and its bench.
package iob_rom_np_arb_pkg;

    localparam int unsigned IOB_ROM_NP_ARB_MAX_PORTS = 16;
    localparam int unsigned IOB_ROM_NP_ARB_IDX_W     = 4;

    // Pointer width for a given port count; a single port still gets one bit.
    function automatic int unsigned ptr_w(input int unsigned n_ports);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n_ports) w++;
        return w;
    endfunction

    // Index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic logic [IOB_ROM_NP_ARB_IDX_W-1:0] onehot_to_idx(
        input logic [IOB_ROM_NP_ARB_MAX_PORTS-1:0] oh
    );
        logic [IOB_ROM_NP_ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < IOB_ROM_NP_ARB_MAX_PORTS; i++) begin
            if (oh[i]) idx = idx | IOB_ROM_NP_ARB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/iob_rom_sp.sv
// Single-port synchronous ROM: registered read, output holds while en is low.
// Contents are a fixed address-derived image selected by HEXFILE.
module iob_rom_sp #(
    parameter string       HEXFILE = "none",
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [31:0] SEED = (HEXFILE == "none") ? 32'h5A5A_0000 : 32'hC3C3_0000;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'((32'(a) * 32'h9E37_79B1) ^ SEED);
    endfunction

    always_ff @(posedge clk) begin
        if (en) rdata <= rom_word(addr);
    end

endmodule

// File: rtl/iob_rr_arb.sv
// Round-robin arbiter: one-hot grant searched upward from rr_ptr with wrap;
// the pointer moves just past the served port whenever advance is high.
module iob_rr_arb
    import iob_rom_np_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = 2
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [N_PORTS-1:0] req,
    input  logic               advance,
    output logic [N_PORTS-1:0] grant
);

    localparam int unsigned PTR_W = ptr_w(N_PORTS);

    logic [PTR_W-1:0]                    rr_ptr;
    logic [PTR_W-1:0]                    ptr_nxt;
    logic [IOB_ROM_NP_ARB_MAX_PORTS-1:0] grant_ext;
    logic [IOB_ROM_NP_ARB_IDX_W-1:0]     grant_idx;

    always_comb begin
        int unsigned pos;
        logic        found;
        grant = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned off = 0; off < N_PORTS; off++) begin
            pos = 32'(rr_ptr) + off;
            if (pos >= N_PORTS) pos = pos - N_PORTS;
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                if (!found && pos == p && req[p]) begin
                    grant[p] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        // No grant may be offered while reset is held.
        if (!arst_n) grant = '0;
    end

    assign grant_ext = IOB_ROM_NP_ARB_MAX_PORTS'(grant);
    assign grant_idx = onehot_to_idx(grant_ext);

    // Wrap explicitly so non-power-of-two port counts never reach unused codes.
    always_comb begin
        ptr_nxt = rr_ptr;
        if (advance) begin
            if (32'(grant_idx) + 32'd1 >= N_PORTS) ptr_nxt = '0;
            else                                   ptr_nxt = PTR_W'(32'(grant_idx) + 32'd1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rr_ptr <= '0;
        else         rr_ptr <= ptr_nxt;
    end

endmodule

// File: rtl/iob_rom_np_arb.sv
// N-port ROM front end: round-robin grant, one shared sync ROM, one-hot rvalid tag.
// Optional output stage via `define IOB_ROM_NP_ARB_OUT_REG_EN (latency 1 -> 2).
module iob_rom_np_arb
    import iob_rom_np_arb_pkg::*;
#(
    parameter string       HEXFILE = "none",
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned N_PORTS = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic [N_PORTS-1:0]        req_valid_i,
    input  logic [N_PORTS*ADDR_W-1:0] req_addr_i,
    output logic [N_PORTS-1:0]        req_ready_o,
    output logic [N_PORTS-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [N_PORTS-1:0] grant;
    logic [N_PORTS-1:0] accept;
    logic [N_PORTS-1:0] grant_q;
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_rdata;

    iob_rr_arb #(
        .N_PORTS (N_PORTS)
    ) u_arb (
        .clk     (clk_i),
        .arst_n  (arst_n_i),
        .req     (req_valid_i),
        .advance (rom_en),
        .grant   (grant)
    );

    assign req_ready_o = grant;
    assign accept      = req_valid_i & grant;
    assign rom_en      = |accept;

    // accept is one-hot, so an OR of masked addresses is the mux.
    always_comb begin
        rom_addr = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            if (accept[k]) rom_addr = rom_addr | req_addr_i[k*ADDR_W +: ADDR_W];
        end
    end

    iob_rom_sp #(
        .HEXFILE (HEXFILE),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_rom (
        .clk   (clk_i),
        .en    (rom_en),
        .addr  (rom_addr),
        .rdata (rom_rdata)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) grant_q <= '0;
        else           grant_q <= accept;
    end

`ifdef IOB_ROM_NP_ARB_OUT_REG_EN
    logic [N_PORTS-1:0] rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= grant_q;
            if (|grant_q) rdata_q <= rom_rdata;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`else
    assign rvalid_o = grant_q;
    assign rdata_o  = rom_rdata;
`endif

endmodule

// File: tb/tb_iob_rom_np_arb.sv
// Directed bench for iob_rom_np_arb: 4-port table-driven run plus a 3-port wrap check.
module tb_iob_rom_np_arb;
    import iob_rom_np_arb_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
`ifdef IOB_ROM_NP_ARB_OUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    localparam logic [NP*AW-1:0] A_ALL  = {10'h3FF, 10'h200, 10'h001, 10'h000};
    localparam logic [NP*AW-1:0] A_MISC = {10'h155, 10'h005, 10'h155, 10'h155};
    localparam logic [NP*AW-1:0] A_SKIP = {10'h0AA, 10'h155, 10'h033, 10'h155};
    localparam logic [NP*AW-1:0] A_WD   = {10'h155, 10'h0F0, 10'h155, 10'h00F};
    localparam logic [3*AW-1:0]  A3     = {10'h022, 10'h011, 10'h3FE};

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic [NP-1:0]    valid, ready, rvalid;
    logic [NP*AW-1:0] addr;
    logic [DW-1:0]    rdata;
    logic [2:0]       valid3, ready3, rvalid3;
    logic [3*AW-1:0]  addr3;
    logic [DW-1:0]    rdata3;

    always #5 clk = ~clk;

    iob_rom_np_arb #(.HEXFILE("none"), .DATA_W(DW), .ADDR_W(AW), .N_PORTS(NP)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .req_valid_i(valid), .req_addr_i(addr),
        .req_ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata)
    );

    iob_rom_np_arb #(.HEXFILE("none"), .DATA_W(DW), .ADDR_W(AW), .N_PORTS(3)) dut3 (
        .clk_i(clk), .arst_n_i(arst_n), .req_valid_i(valid3), .req_addr_i(addr3),
        .req_ready_o(ready3), .rvalid_o(rvalid3), .rdata_o(rdata3)
    );

    typedef struct {
        logic [NP-1:0]    valid;
        logic [NP*AW-1:0] addr;
        logic [NP-1:0]    exp_ready;
    } vec_t;

    vec_t          vecs [15];
    int unsigned   checks;
    int unsigned   failures;
    logic [NP-1:0] sh_oh   [1:2];
    logic [DW-1:0] sh_word [1:2];
    logic [DW-1:0] last_word;
    logic          have_last;

    // Reference image of the ROM built-in contents for HEXFILE="none".
    function automatic logic [DW-1:0] rom_model(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_pipe();
        sh_oh[1] = '0; sh_oh[2] = '0; sh_word[1] = '0; sh_word[2] = '0;
`ifdef IOB_ROM_NP_ARB_OUT_REG_EN
        last_word = '0; have_last = 1'b1;
`else
        last_word = '0; have_last = 1'b0;
`endif
    endtask

    task automatic check_return(input string name);
        check({name, " rvalid"}, 32'(rvalid), 32'(sh_oh[LAT]));
        if (sh_oh[LAT] != '0) begin
            check({name, " rdata"}, rdata, sh_word[LAT]);
            last_word = sh_word[LAT];
            have_last = 1'b1;
        end else if (have_last) begin
            check({name, " rdata_hold"}, rdata, last_word);
        end
    endtask

    task automatic step(input logic [NP-1:0] v, input logic [NP*AW-1:0] a,
                        input logic [NP-1:0] exp_rdy, input string name);
        logic [NP-1:0] acc_oh;
        int unsigned   g;
        @(negedge clk);
        valid = v;
        addr  = a;
        #1;
        check({name, " ready"}, 32'(ready), 32'(exp_rdy));
        check_return(name);
        acc_oh = exp_rdy & v;
        g = 32'(onehot_to_idx(IOB_ROM_NP_ARB_MAX_PORTS'(acc_oh)));
        @(posedge clk);
        sh_oh[2]   = sh_oh[1];
        sh_word[2] = sh_word[1];
        sh_oh[1]   = acc_oh;
        sh_word[1] = rom_model(a[g*AW +: AW]);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        valid  = '1;
        addr   = A_ALL;
        valid3 = '1;
        addr3  = A3;
        #1;
        check("rst ready", 32'(ready), 32'd0);
        check("rst ready3", 32'(ready3), 32'd0);
        check("rst rvalid", 32'(rvalid), 32'd0);
`ifdef IOB_ROM_NP_ARB_OUT_REG_EN
        check("rst rdata", rdata, 32'd0);
`endif
        repeat (2) @(negedge clk);
        valid  = '0;
        valid3 = '0;
        arst_n = 1'b1;
        clear_pipe();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]    exp3  [6];
        logic [2:0]    p3_oh [1:2];
        logic [DW-1:0] p3_wd [1:2];
        int unsigned   g3;

        checks = 0;
        failures = 0;
        valid = '0; addr = '0; valid3 = '0; addr3 = '0;

        vecs[0]  = '{4'b0100, A_MISC, 4'b0100};
        vecs[1]  = '{4'b0000, A_MISC, 4'b0000};
        vecs[2]  = '{4'b1111, A_ALL,  4'b1000};
        vecs[3]  = '{4'b1111, A_ALL,  4'b0001};
        vecs[4]  = '{4'b1111, A_ALL,  4'b0010};
        vecs[5]  = '{4'b1111, A_ALL,  4'b0100};
        vecs[6]  = '{4'b1111, A_ALL,  4'b1000};
        vecs[7]  = '{4'b1111, A_ALL,  4'b0001};
        vecs[8]  = '{4'b0010, A_SKIP, 4'b0010};
        vecs[9]  = '{4'b1010, A_SKIP, 4'b1000};
        vecs[10] = '{4'b1010, A_SKIP, 4'b0010};
        vecs[11] = '{4'b0101, A_WD,   4'b0100};
        vecs[12] = '{4'b0100, A_WD,   4'b0100};
        vecs[13] = '{4'b0000, A_WD,   4'b0000};
        vecs[14] = '{4'b0000, A_WD,   4'b0000};

        do_reset();
        for (int unsigned i = 0; i < 15; i++) begin
            step(vecs[i].valid, vecs[i].addr, vecs[i].exp_ready, $sformatf("vec%0d", i));
        end

        // Reset pulse right after an acceptance: the read is dropped, pointer restarts at 0.
        step(4'b0100, A_MISC, 4'b0100, "pre_rst");
        #1 arst_n = 1'b0;
        #1 check("midrst rvalid", 32'(rvalid), 32'd0);
        #1 arst_n = 1'b1;
        clear_pipe();
        step(4'b1111, A_ALL, 4'b0001, "post_rst0");
        step(4'b1111, A_ALL, 4'b0010, "post_rst1");
        step(4'b0000, A_ALL, 4'b0000, "post_rst2");
        step(4'b0000, A_ALL, 4'b0000, "post_rst3");

        // Three ports: pointer must wrap 2 -> 0.
        exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
        p3_oh[1] = '0; p3_oh[2] = '0; p3_wd[1] = '0; p3_wd[2] = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk);
            valid3 = (i < 4) ? 3'b111 : 3'b000;
            addr3  = A3;
            #1;
            check($sformatf("np3 step%0d ready", i), 32'(ready3), 32'(exp3[i]));
            check($sformatf("np3 step%0d rvalid", i), 32'(rvalid3), 32'(p3_oh[LAT]));
            if (p3_oh[LAT] != '0) check($sformatf("np3 step%0d rdata", i), rdata3, p3_wd[LAT]);
            g3 = 32'(onehot_to_idx(IOB_ROM_NP_ARB_MAX_PORTS'(exp3[i])));
            @(posedge clk);
            p3_oh[2] = p3_oh[1];
            p3_wd[2] = p3_wd[1];
            p3_oh[1] = exp3[i];
            p3_wd[1] = rom_model(A3[g3*AW +: AW]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_rom_np_arb.md
Name: iob_rom_np_arb

Overview:
- Single-port synchronous ROM shared by N_PORTS read clients, with a round-robin arbiter and a per-port valid/ready request handshake.
- Per-port read-data-valid strobes.
- Successor to the fixed-priority two-port ROM wrapper: generalised port count, fair arbitration, explicit return-data tagging.
- Sits between several CPU/DMA fetch masters and one boot/firmware ROM.

Parameters:
- HEXFILE, "none", ROM init file passed to the internal ROM.
- DATA_W, 32, ROM word width.
- ADDR_W, 10, word address width; depth = 2**ADDR_W.
- N_PORTS, 2, number of read clients; legal range 1..16.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  N_PORTS  per-port read request.
- req_addr_i  in  N_PORTS*ADDR_W  per-port address; port k uses bits [k*ADDR_W +: ADDR_W].
- req_ready_o  out  N_PORTS  one-hot (or zero) grant; request accepted when valid&ready.
- rvalid_o  out  N_PORTS  one-hot strobe; rdata_o belongs to this port in this cycle.
- rdata_o  out  DATA_W  shared read data.

Behaviour:
- Clock and reset: one clock (clk_i); reset is asynchronous and active-low (arst_n_i).
- Reset values:
  - rr_ptr = 0.
  - rvalid_o = 0.
  - req_ready_o = 0 while in reset.
  - rdata_o undefined until the first rvalid (0 when the optional feature is enabled).
- Arbitration:
  - Combinational, at most one grant per cycle.
  - Search order starts at rr_ptr, ascending with wrap: rr_ptr, rr_ptr+1, …, N_PORTS-1, 0, …
  - First port with req_valid_i=1 gets req_ready_o=1.
  - No request: all ready=0, ROM enable=0.
- Pointer update:
  - On an accepted request from port g, rr_ptr <= (g+1) mod N_PORTS.
  - With no grant, rr_ptr holds.
  - With N_PORTS not a power of two, the pointer wraps at N_PORTS-1 -> 0, never reaching unused codes.
- ROM access:
  - ROM enable = OR of handshakes; ROM address = granted port's address.
  - Sync ROM: data available 1 cycle after acceptance.
- Return path:
  - Grant index registered as a one-hot vector; rvalid_o equals it one cycle after acceptance (latency 1).
  - rdata_o valid only while rvalid_o is nonzero; otherwise it holds the last read word because the ROM is not re-enabled.
- Throughput: one accepted read per cycle, back-to-back across any ports.
- Fairness: with all ports continuously requesting, each port is served exactly once every N_PORTS cycles.
- Request hold rule: none. A master may drop valid at any time; an ungranted request leaves no state.
- Reset mid-operation: an in-flight read is discarded, rvalid_o forced 0, and rr_ptr returns to 0.
- N_PORTS=1: ready = valid, and the pointer is a constant 0.

Optional Feature:
- Macro: IOB_ROM_NP_ARB_OUT_REG_EN.
- Defined:
  - Adds an output register stage on rdata_o and rvalid_o; latency becomes 2 cycles; throughput unchanged.
  - The rdata_o register resets to 0 and loads only when the delayed strobe is nonzero.
- Undefined: latency 1, rdata_o driven directly from the ROM.

Decomposition:
- Shared package/header:
  - IOB_ROM_NP_ARB_MAX_PORTS = 16.
  - Pointer width function clog2(N_PORTS), with minimum 1.
  - One-hot-to-index function, reused by the arbiter and the testbench.
- Sub-module iob_rr_arb (N_PORTS), parameterised round-robin arbiter:
  - Inputs req and an advance signal; outputs a one-hot grant.
  - Holds rr_ptr with async active-low reset.
- Top module instantiates iob_rr_arb plus the existing single-port ROM (iob_rom_sp).

Test Plan:
- Reset, then a single read: N_PORTS=4, port 2 requests addr 0x005 -> ready[2]=1 same cycle; next cycle rvalid_o=4'b0100 and rdata_o=ROM[5].
- All ports continuously requesting addresses k: grant sequence 0,1,2,3,0,…; rvalid one cycle behind; each rdata_o=ROM[k] of the strobed port.
- Pointer skip: ports 1 and 3 request after port 1 was last served -> port 3 granted first, then port 1.
- Request withdrawn: port 0 raises valid for one cycle while port 2 holds the grant, then drops it -> port 0 never strobed; no spurious rvalid.
- Async reset pulse one cycle after acceptance: rvalid_o stays 0 and the next grant starts from port 0.
- With IOB_ROM_NP_ARB_OUT_REG_EN: same as the single-read scenario but rvalid_o/rdata_o appear 2 cycles after acceptance; rdata_o=0 after reset.
